// File: rtl/sobel_edge_pipe_if.sv
// Window-in / pixel-out stream bundle for the Sobel pipeline.
// master = window generator + pixel writer side, slave = the pipeline.
interface sobel_edge_pipe_if #(
    parameter int PIX_W = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [2:0][2:0][PIX_W-1:0]    comp_matrix;
    logic [PIX_W+2:0]              threshold;
    logic                          out_valid;
    logic                          out_ready;
    logic                          edge_pixel;
    logic [PIX_W-1:0]              mag_pixel;
    logic                          sobel_done;

    modport master (
        output in_valid, comp_matrix, threshold, out_ready,
        input  in_ready, out_valid, edge_pixel, mag_pixel, sobel_done
    );

    modport slave (
        input  in_valid, comp_matrix, threshold, out_ready,
        output in_ready, out_valid, edge_pixel, mag_pixel, sobel_done
    );
endinterface

// File: rtl/sobel_edge_pipe.sv
// Three-stage Sobel |Gx|+|Gy| edge detector with valid/ready flow control
// and an end-of-frame pulse after FRAME_PIX output pixels.
module sobel_edge_pipe #(
    parameter int PIX_W     = 8,
    parameter int FRAME_PIX = 4096
) (
    input  logic               clk,
    input  logic               rst,
    sobel_edge_pipe_if.slave   bus
);
    localparam int GW    = PIX_W + 3;
    localparam int CNT_W = $clog2(FRAME_PIX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIX - 1);

    function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return GW'(p);
    endfunction

    // |g| always fits: the gradient magnitude never exceeds 4*(2^PIX_W-1).
    function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] g);
        logic [GW-1:0] r;
        r = g[GW-1] ? GW'(-g) : GW'(g);
        return r;
    endfunction

    function automatic logic [PIX_W-1:0] sat_mag(input logic [GW-1:0] s);
        return (s[GW-1:PIX_W] != '0) ? '1 : s[PIX_W-1:0];
    endfunction

    logic advance;
    logic out_hs;

    logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GW-1:0] gx_c, gy_c;

    logic signed [GW-1:0] gx_p0, gy_p0;
    logic [GW-1:0]        thr_p0;
    logic                 vld_p0;

    logic [GW-1:0]        sum_p1;
    logic [GW-1:0]        thr_p1;
    logic                 vld_p1;

    logic                 vld_p2;
    logic                 edge_p2;
    logic [PIX_W-1:0]     mag_p2;

    logic [CNT_W-1:0]     pix_cnt;
    logic                 done_q;

    assign advance       = ~(vld_p2 & ~bus.out_ready);
    assign out_hs        = vld_p2 & bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_p2;
    assign bus.edge_pixel = edge_p2;
    assign bus.mag_pixel = mag_p2;
    assign bus.sobel_done = done_q;

    // Positive and negative kernel halves are non-negative and fit in GW bits,
    // so the modular difference is the correct two's-complement gradient.
    always_comb begin
        gx_pos = ext(bus.comp_matrix[0][2]) + (ext(bus.comp_matrix[1][2]) << 1)
               + ext(bus.comp_matrix[2][2]);
        gx_neg = ext(bus.comp_matrix[0][0]) + (ext(bus.comp_matrix[1][0]) << 1)
               + ext(bus.comp_matrix[2][0]);
        gy_pos = ext(bus.comp_matrix[2][0]) + (ext(bus.comp_matrix[2][1]) << 1)
               + ext(bus.comp_matrix[2][2]);
        gy_neg = ext(bus.comp_matrix[0][0]) + (ext(bus.comp_matrix[0][1]) << 1)
               + ext(bus.comp_matrix[0][2]);
        gx_c   = signed'(gx_pos - gx_neg);
        gy_c   = signed'(gy_pos - gy_neg);
    end

    // ---- S1/S2 data: gradients, then sum; threshold rides along ----
    always_ff @(posedge clk) begin
        if (advance) begin
            gx_p0  <= gx_c;
            gy_p0  <= gy_c;
            thr_p0 <= bus.threshold;
            sum_p1 <= abs_g(gx_p0) + abs_g(gy_p0);
            thr_p1 <= thr_p0;
        end
    end

    // ---- stage valids and S3 output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            edge_p2 <= 1'b0;
            mag_p2  <= '0;
        end else if (advance) begin
            vld_p0  <= bus.in_valid;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            edge_p2 <= (sum_p1 > thr_p1);
            mag_p2  <= sat_mag(sum_p1);
        end
    end

    // ---- frame counter: pulse follows the handshake of the last pixel ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_hs) begin
                if (pix_cnt == LAST_CNT) begin
                    pix_cnt <= '0;
                    done_q  <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Directed + random bench for sobel_edge_pipe against an integer Sobel model,
// with a FIFO scoreboard for ordering and a handshake-count model for sobel_done.
module tb_sobel_edge_pipe;
    localparam int PIX_W     = 8;
    localparam int TW        = PIX_W + 3;
    localparam int FRAME_PIX = 4;
    localparam int MAXV      = (1 << PIX_W) - 1;

    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    logic tb_clk;
    logic rst;

    sobel_edge_pipe_if #(.PIX_W(PIX_W)) bus ();

    sobel_edge_pipe #(.PIX_W(PIX_W), .FRAME_PIX(FRAME_PIX)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit q_edge[$];
    int q_mag[$];
    int cnt_m     = 0;
    int n_done    = 0;
    int last_edge = -1;
    int last_mag  = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_calc(input win_t w, input int thr, output bit e, output int m);
        int p[3][3];
        int gx, gy, s;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = int'(w[r][c]);
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e  = (s > thr);
        m  = (s > MAXV) ? MAXV : s;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = PIX_W'($urandom);
        return w;
    endfunction

    // One clock: drive, settle, predict handshakes, clock, check.
    task automatic step(input bit v, input win_t w, input int thr, input bit ordy);
        bit acc, ohs, stall, exp_done, e;
        int m, h_edge, h_mag;
        bus.in_valid    = v;
        bus.comp_matrix = w;
        bus.threshold   = TW'(thr);
        bus.out_ready   = ordy;
        #1;
        stall = bus.out_valid && !ordy;
        chk("in_ready", int'(bus.in_ready), int'(!stall));
        acc = v && bus.in_ready;
        ohs = bus.out_valid && ordy;
        exp_done = 1'b0;
        if (ohs) begin
            chk("out_expected", int'(q_mag.size() > 0), 1);
            if (q_mag.size() > 0) begin
                chk("edge", int'(bus.edge_pixel), int'(q_edge.pop_front()));
                chk("mag", int'(bus.mag_pixel), q_mag.pop_front());
            end
            last_edge = int'(bus.edge_pixel);
            last_mag  = int'(bus.mag_pixel);
            cnt_m++;
            if (cnt_m == FRAME_PIX) begin
                exp_done = 1'b1;
                cnt_m = 0;
            end
        end
        h_edge = int'(bus.edge_pixel);
        h_mag  = int'(bus.mag_pixel);
        if (acc) begin
            ref_calc(w, thr, e, m);
            q_edge.push_back(e);
            q_mag.push_back(m);
        end
        @(posedge tb_clk);
        #1;
        chk("sobel_done", int'(bus.sobel_done), int'(exp_done));
        if (bus.sobel_done) n_done++;
        if (stall) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_edge", int'(bus.edge_pixel), h_edge);
            chk("hold_mag", int'(bus.mag_pixel), h_mag);
        end
    endtask

    task automatic drain();
        win_t z;
        z = '0;
        for (int i = 0; i < 40 && q_mag.size() > 0; i++) step(1'b0, z, 0, 1'b1);
        chk("drain_empty", q_mag.size(), 0);
        step(1'b0, z, 0, 1'b1);
        step(1'b0, z, 0, 1'b1);
    endtask

    initial begin
        win_t w, z;
        int d0;
        z = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.comp_matrix = '0;
        bus.threshold = '0;
        bus.out_ready = 1'b0;
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_done", int'(bus.sobel_done), 0);
        chk("rst_edge", int'(bus.edge_pixel), 0);
        chk("rst_mag", int'(bus.mag_pixel), 0);
        rst = 1'b0;
        @(posedge tb_clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // Flat window, latency
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = PIX_W'(MAXV);
        step(1'b1, w, 128, 1'b1);
        chk("lat_edge1", int'(bus.out_valid), 0);
        step(1'b0, z, 0, 1'b1);
        chk("lat_edge2", int'(bus.out_valid), 0);
        step(1'b0, z, 0, 1'b1);
        chk("lat_edge3", int'(bus.out_valid), 1);
        drain();
        chk("flat_edge", last_edge, 0);
        chk("flat_mag", last_mag, 0);

        // Saturating strong edge: Gx=846, Gy=-88, sum=934
        w = '0;
        w[0][1] = 156; w[1][1] = 111; w[2][1] = 123;
        w[0][2] = 200; w[1][2] = 234; w[2][2] = 178;
        step(1'b1, w, 128, 1'b1);
        drain();
        chk("sat_edge", last_edge, 1);
        chk("sat_mag", last_mag, 255);

        // Strict threshold boundary at sum=4
        w = '0;
        w[0][2] = 1; w[1][2] = 1; w[2][2] = 1;
        step(1'b1, w, 4, 1'b1);
        drain();
        chk("thr_eq_edge", last_edge, 0);
        chk("thr_eq_mag", last_mag, 4);
        step(1'b1, w, 3, 1'b1);
        drain();
        chk("thr_lt_edge", last_edge, 1);
        chk("thr_lt_mag", last_mag, 4);

        // Back-to-back then a 5-cycle output stall with input still offered
        for (int i = 0; i < 8; i++) step(1'b1, rand_win(), int'($urandom_range(0, 1500)), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rand_win(), int'($urandom_range(0, 1500)), 1'b0);
            chk("stall_in_ready", int'(bus.in_ready), 0);
        end
        drain();

        // Frame pulses: 9 windows from a frame boundary -> 2 pulses
        chk("frame_aligned", cnt_m, 0);
        d0 = n_done;
        for (int i = 0; i < 9; i++) step(1'b1, rand_win(), int'($urandom_range(0, 2047)), 1'b1);
        drain();
        chk("frame_pulses", n_done - d0, 2);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++)
            step(1'(($urandom % 4) != 0), rand_win(), int'($urandom_range(0, 2047)),
                 1'(($urandom % 10) < 7));
        drain();

        // Reset with three windows in flight and out_ready high on the reset edge
        step(1'b0, z, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, rand_win(), int'($urandom_range(0, 2047)), 1'b0);
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        q_edge.delete();
        q_mag.delete();
        cnt_m = 0;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_done", int'(bus.sobel_done), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        d0 = n_done;
        for (int i = 0; i < FRAME_PIX - 1; i++) step(1'b1, rand_win(), int'($urandom_range(0, 2047)), 1'b1);
        drain();
        chk("post_rst_no_pulse", n_done - d0, 0);
        step(1'b1, rand_win(), 100, 1'b1);
        drain();
        chk("post_rst_pulse", n_done - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
